// File: rtl/prod_handshake_engine.sv
// Signed DW x DW shift-add multiply engine: start falling edge -> read A,B -> product written little-endian -> done (DW+4 cycles).
// No backpressure; memory is single-cycle. Optional PROD_SELFCHECK_EN adds a simulation-only product check at WR_LO.
`timescale 1ns/1ps
module prod_handshake_engine #(
   parameter int DW     = 8,
   parameter int AW     = 8,
   parameter int ADDR_A = 0,
   parameter int ADDR_B = 1,
   parameter int ADDR_P = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_wr_en,
   output logic [DW-1:0] mem_wdata
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [2:0] {
      IDLE, RD_A, RD_B, MUL, WR_LO, WR_HI, DONE
   } state_t;

   state_t          state, state_nx;
   logic            start_q;
   logic [DW-1:0]   a, b;
   logic [2*DW-1:0] acc;
   logic [CW-1:0]   cnt;
   logic [2*DW-1:0] a_sh;
   logic            last_bit;

   assign last_bit = (cnt == CW'(DW-1));
   assign a_sh     = {{DW{a[DW-1]}}, a} << cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Outputs are decoded from state (and the acc register) only; start never reaches them combinationally.
   always_comb begin
      state_nx  = state;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wr_en = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:  if (start_q && !start) state_nx = RD_A;
         RD_A: begin
            mem_addr = AW'(ADDR_A);
            state_nx = RD_B;
         end
         RD_B: begin
            mem_addr = AW'(ADDR_B);
            state_nx = MUL;
         end
         MUL:   if (last_bit) state_nx = WR_LO;
         WR_LO: begin
            mem_addr  = AW'(ADDR_P);
            mem_wdata = acc[DW-1:0];
            mem_wr_en = 1'b1;
            state_nx  = WR_HI;
         end
         WR_HI: begin
            mem_addr  = AW'(ADDR_P + 1);
            mem_wdata = acc[2*DW-1:DW];
            mem_wr_en = 1'b1;
            state_nx  = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // The sign bit of b carries negative weight, so its partial product is subtracted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_q <= 1'b0;
         a       <= '0;
         b       <= '0;
         acc     <= '0;
         cnt     <= '0;
      end else begin
         start_q <= start;
         case (state)
            RD_A: a <= mem_rdata;
            RD_B: begin
               b   <= mem_rdata;
               acc <= '0;
               cnt <= '0;
            end
            MUL: begin
               if (b[cnt]) acc <= last_bit ? (acc - a_sh) : (acc + a_sh);
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef PROD_SELFCHECK_EN
   always @(posedge clk) begin
      if (reset && state == WR_LO && $signed(acc) !== ($signed(a) * $signed(b)))
         $error("prod_handshake_engine: a=%0d b=%0d acc=%0d expected=%0d",
                $signed(a), $signed(b), $signed(acc), $signed(a) * $signed(b));
   end
`else
   // Product is trusted as computed; no simulation check in this build.
`endif

endmodule

// File: tb/tb_prod_handshake_engine.sv
// Randomized scoreboard bench for prod_handshake_engine with a behavioural product model and a data-memory model.
`timescale 1ns/1ps
module tb_prod_handshake_engine;
   localparam int DW = 8;
   localparam int AW = 8;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b1;
   logic          done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic          mem_wr_en;
   logic [DW-1:0] mem_wdata;

   logic [7:0] dm [0:255];
   logic       tb_wr   = 1'b0;
   logic [7:0] tb_addr = '0;
   logic [7:0] tb_dat  = '0;

   int cyc = 0, wr_total = 0, wr_seen = 0, bad_wr = 0;
   int n_chk = 0, n_fail = 0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      int          e0;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   prod_handshake_engine #(.DW(DW), .AW(AW), .ADDR_A(0), .ADDR_B(1), .ADDR_P(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata)
   );

   assign mem_rdata = dm[mem_addr];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_wr_en) begin
         dm[mem_addr] <= mem_wdata;
         wr_total     <= wr_total + 1;
         if (mem_addr != 8'd2 && mem_addr != 8'd3) bad_wr <= bad_wr + 1;
      end else if (tb_wr) begin
         dm[tb_addr] <= tb_dat;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
      int pa, pb;
      pa = int'($signed(a));
      pb = int'($signed(b));
      return 16'(pa * pb);
   endfunction

   // Monitor: every rising done retires one expected run.
   logic done_d = 1'b0;
   exp_t e;
   always @(negedge clk) begin
      if (reset && done && !done_d) begin
         if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check("prod_lo", 32'(dm[2]), 32'(e.p[7:0]));
            check("prod_hi", 32'(dm[3]), 32'(e.p[15:8]));
            check("opa_kept", 32'(dm[0]), 32'(e.a));
            check("opb_kept", 32'(dm[1]), 32'(e.b));
            check("latency", 32'(cyc - e.e0), 32'd12);
            check("writes_per_run", 32'(wr_total - wr_seen), 32'd2);
         end
         wr_seen = wr_total;
      end
      done_d = done;
   end

   task automatic poke(input logic [7:0] ad, input logic [7:0] d);
      @(negedge clk);
      tb_wr = 1'b1; tb_addr = ad; tb_dat = d;
      @(negedge clk);
      tb_wr = 1'b0;
   endtask

   task automatic launch(input logic [7:0] a, input logic [7:0] b);
      exp_t x;
      poke(8'd0, a);
      poke(8'd1, b);
      poke(8'd2, 8'($urandom));
      poke(8'd3, 8'($urandom));
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      x.a = a; x.b = b; x.p = ref_prod(a, b); x.e0 = cyc + 1;
      q.push_back(x);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("run_timeout", 32'(q.size()), 32'd0);
   endtask

   task automatic finish_run(input int hold);
      repeat (hold) begin
         @(negedge clk);
         check("done_hold", 32'(done), 32'd1);
      end
      start = 1'b1;
      @(negedge clk);
      check("done_fall", 32'(done), 32'd0);
      check("idle_wr_en", 32'(mem_wr_en), 32'd0);
      check("idle_addr", 32'(mem_addr), 32'd0);
   endtask

   logic [7:0] da [4] = '{8'd2, 8'h80, 8'h7F, 8'h00};
   logic [7:0] db [4] = '{8'hFC, 8'h80, 8'h80, 8'hFF};
   logic [7:0] dl [4] = '{8'hF8, 8'h00, 8'h80, 8'h00};
   logic [7:0] dh [4] = '{8'hFF, 8'h40, 8'hC0, 8'h00};

   initial begin
      int wr_snap, seen_done, pulse;
      logic [7:0] ra, rb;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wr_en", 32'(mem_wr_en), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         launch(da[i], db[i]);
         wait_empty();
         check("plan_lo", 32'(dm[2]), 32'(dl[i]));
         check("plan_hi", 32'(dm[3]), 32'(dh[i]));
         finish_run(i == 0 ? 5 : 1);
      end

      for (int i = 0; i < 16; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (i == 0) ra = 8'h80;
         if (i == 1) rb = 8'h7F;
         launch(ra, rb);
         wait_empty();
         finish_run(int'($urandom_range(1, 3)));
      end

      // Reset during the 4th multiply cycle must not disturb the product bytes.
      poke(8'd0, 8'd3);
      poke(8'd1, 8'd5);
      poke(8'd2, 8'h5A);
      poke(8'd3, 8'h5A);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      wr_snap = wr_total;
      repeat (6) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_done", 32'(done), 32'd0);
      check("abort_wr_en", 32'(mem_wr_en), 32'd0);
      @(negedge clk) reset = 1'b1;
      seen_done = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      check("abort_no_writes", 32'(wr_total - wr_snap), 32'd0);
      check("abort_lo_kept", 32'(dm[2]), 32'h5A);
      check("abort_hi_kept", 32'(dm[3]), 32'h5A);
      launch(8'd3, 8'd5);
      wait_empty();
      finish_run(1);

      // start toggled during the run: the second fall is ignored and done lasts one cycle.
      launch(8'hF3, 8'h19);
      repeat (4) @(negedge clk);
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      pulse = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) pulse++;
      end
      check("pulse_len", 32'(pulse), 32'd1);
      check("pulse_queue", 32'(q.size()), 32'd0);

      check("bad_writes", 32'(bad_wr), 32'd0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/prod_handshake_engine.md
# prod_handshake_engine

Hardware responder for the program-2 start/done handshake. On a falling edge of `start` it reads two 8-bit two's-complement operands from data memory and computes their signed 16-bit product with a sequential shift-add multiplier. It writes the product back little-endian and raises `done`. It sits beside data memory as the fixed-function counterpart to the program-2 bench, and serves as a golden engine when checking the processor's results.

## Interface
Parameters:
- `DW`, 8, operand width; product width is 2*`DW`
- `AW`, 8, data-memory address width
- `ADDR_A`, 0, address of operand A
- `ADDR_B`, 1, address of operand B
- `ADDR_P`, 2, address of product low byte; high byte at `ADDR_P`+1

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `start`  in  1  request; a high-to-low transition initiates a run
- `done`  out  1  acknowledge; high when the product is in memory
- `mem_addr`  out  `AW`  data-memory address
- `mem_rdata`  in  `DW`  read data, combinational from `mem_addr` (same cycle)
- `mem_wr_en`  out  1  write strobe; memory writes on the rising `clk` when high
- `mem_wdata`  out  `DW`  write data

## Operation
- States: IDLE, RD_A, RD_B, MUL, WR_LO, WR_HI, DONE.
- `start_q` registers `start` and resets to 0. A falling edge is `start_q`=1 and `start`=0.
- IDLE: `mem_wr_en`=0. On a falling edge, go to RD_A.
- RD_A: `mem_addr`=`ADDR_A`; capture the multiplicand into register `a`.
- RD_B: `mem_addr`=`ADDR_B`; capture the multiplier into register `b`; clear the 2*`DW` accumulator; clear the bit counter.
- MUL runs `DW` cycles, counter i = 0..`DW`-1:
  - If b[i]=1 and i<`DW`-1: acc += sext(a) << i.
  - If b[i]=1 and i=`DW`-1: acc -= sext(a) << i. This handles the negative weight of the sign bit.
  - Arithmetic is modulo 2^(2*`DW`). The result is exact for all operand pairs, including -128 * -128 = +16384.
- WR_LO: `mem_addr`=`ADDR_P`, `mem_wdata`=acc[`DW`-1:0], `mem_wr_en`=1.
- WR_HI: `mem_addr`=`ADDR_P`+1, `mem_wdata`=acc[2*`DW`-1:`DW`], `mem_wr_en`=1. Then go to DONE.
- DONE: `done`=1. Stay while `start`=0. When `start`=1 is sampled, go to IDLE; `done` falls on that edge.
- Falling edges of `start` outside IDLE are ignored.
- A rise of `start` during RD_A..WR_HI is ignored; the run completes normally. Because `start` is already high on entering DONE, `done` is then high for exactly one cycle.
- Memory is only ever written in WR_LO and WR_HI. Operand locations are never written.

## Timing
- Reset values: state=IDLE, `done`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0, `start_q`=0, acc=0.
- Edge E0 samples the falling edge. Then:
  - RD_A occupies E1.
  - RD_B occupies E2.
  - MUL occupies E3..E(2+`DW`).
  - The low byte is written at E(3+`DW`).
  - The high byte is written at E(4+`DW`), and `done` rises after that same edge.
- Latency from E0 to `done` high is `DW`+4 cycles, which is 12 for `DW`=8.
- If `start` is already low when reset deasserts, no run starts (`start_q` resets to 0). A new high-then-low sequence is required.
- Reset asserted mid-run returns to IDLE immediately and drops `done` and `mem_wr_en`. A partial product is never written if reset hits before WR_LO. A run cut during WR_HI leaves only the low byte updated.
- All outputs are registered or decoded from state only; none depends combinationally on `start`.

## Configuration
- `PROD_SELFCHECK_EN` defined:
  - Compiles a simulation-only check.
  - At WR_LO, acc is compared against $signed(a)*$signed(b).
  - Any mismatch reports `$error` with both operands and both values.
  - No ports or timing change.
- `PROD_SELFCHECK_EN` undefined: the check is absent; the logic is fully synthesizable and identical in behaviour.

## Test plan
- dm[0]=2, dm[1]=-4; reset released; `start` 1->0 -> dm[2]=0xF8, dm[3]=0xFF; `done` high exactly 12 cycles after the sampled edge.
- dm[0]=-128, dm[1]=-128 -> dm[2]=0x00, dm[3]=0x40. Also dm[0]=127, dm[1]=-128 -> dm[2]=0x80, dm[3]=0xC0.
- dm[0]=0, dm[1]=-1 -> dm[2]=0x00, dm[3]=0x00; dm[0], dm[1] unchanged.
- Reset pulsed low during the 4th MUL cycle with dm[2], dm[3] preloaded to 0x5A -> `done` stays 0, dm[2], dm[3] remain 0x5A. A fresh start edge then gives the correct product.
- `start` raised mid-run and dropped again before WR_HI -> the second edge is ignored, `done` pulses high for one cycle, and exactly two memory writes occur.
- `start` held low after `done` -> `done` stays high. Raise `start` -> `done`=0 one cycle later and the state is IDLE.
